node_frame_rx: RTL and testbench
================================

# node_frame_rx

Per-node receive endpoint of the L2 switch: it takes 12-bit frames from one switch egress port, keeps those addressed to this node or broadcast, and buffers them in a small FIFO for the LCD/LED display path. It is the consuming end of the frames that the send-button transmit path injects. It sits between a switch egress port and the node's display logic. One instance is used per node (A–D).

## Interface
Parameters:
- NODE_ADDR, 4'hA — this node's 4-bit address.
- FIFO_DEPTH, 4 — buffered frames; power of two, 2..16.
- LED_HOLD, 16 — cycles the receive LED stays lit after an accepted frame; ≥1, 16-bit range.

Ports:
- FPGA_CLK  in  1 — sole clock, rising edge.
- FPGA_RST_BTN  in  1 — reset; one clock; reset is asynchronous and active-low.
- rx_valid  in  1 — egress frame valid.
- rx_ready  out  1 — endpoint can take a frame.
- rx_frame  in  12 — {dst[11:8], src[7:4], payload[3:0]}.
- out_valid  out  1 — FIFO head valid.
- out_ready  in  1 — display consumer pops head.
- out_src  out  4 — head frame source address.
- out_payload  out  4 — head frame payload.
- last_payload  out  4 — payload of most recent accepted frame.
- rx_led  out  1 — stretched "frame received" indicator.
- rx_count  out  8 — accepted frames, saturating at 8'hFF.
- drop_count  out  8 — misaddressed frames, saturating at 8'hFF.

## Operation
- Handshake: a transfer occurs on a rising edge with rx_valid && rx_ready. rx_ready = !fifo_full, registered-state derived, with no combinational path from rx_valid. A frame held under rx_ready=0 must stay stable until transferred.
- Filter on each transfer:
  - dst == NODE_ADDR or dst == 4'hF (broadcast): accepted. The frame is pushed {src,payload}, last_payload ← payload, rx_count +1 (saturating), and the LED timer is loaded with LED_HOLD.
  - Otherwise: consumed but discarded, drop_count +1 (saturating). The FIFO, last_payload and LED are untouched.
- FIFO:
  - First-word-fall-through. out_src and out_payload show the head whenever out_valid=1; they are don't-care when out_valid=0.
  - A pop happens on out_valid && out_ready.
  - Pointers are log2(FIFO_DEPTH) bits and wrap. Occupancy is tracked with a (log2+1)-bit count.
- LED timer: 16-bit down-counter; rx_led = (timer != 0). It decrements by 1 per cycle when nonzero. An accepted frame reloads it to LED_HOLD (retrigger), and the reload wins over the decrement.
- Reset (asynchronous, any time, including mid-transfer): pointers and count go to 0. out_valid=0, rx_ready=1 after reset deasserts, last_payload=0, rx_led=0, timer=0, rx_count=0, drop_count=0. FIFO contents are don't-care. Frames in flight are lost.

## Timing
- Accept → out_valid: one cycle. A frame transferred at edge N is visible at the head after edge N, when the FIFO was empty.
- Accept → last_payload, rx_count, rx_led: updated at the same edge N.
- Pop → next head: the following entry is presented after the popping edge.
- Full (count == FIFO_DEPTH): rx_ready=0 and no push occurs. A pop at edge N raises rx_ready after edge N.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: count is unchanged and both pointers advance.
  - Empty FIFO: no pop occurs because out_valid=0; the push lands.
- Misaddressed frame while full: it is not transferred, since rx_ready=0, and is not counted.
- Both counters saturate at 8'hFF and hold that value.
- Throughput: one frame per cycle while not full.

## Structure
- Shared package/header holds the following. Transmit-side encoders use the same package.
  - Address constants: NODE_A=4'hA, NODE_B=4'hB, NODE_C=4'hC, NODE_D=4'hD, ADDR_BCAST=4'hF.
  - Frame field slice constants: DST 11:8, SRC 7:4, PAY 3:0.
  - FRAME_W=12.
- Sub-module node_rx_fifo: parameterised FWFT FIFO, width 8, depth FIFO_DEPTH, exposing full/empty/count. The filter, counters and LED timer stay in node_frame_rx.

## Test plan
- NODE_ADDR=4'hC. Send frame 12'hCA5 → rx_ready=1. One cycle later out_valid=1, out_src=A, out_payload=5. last_payload=5, rx_count=1, rx_led=1 for exactly 16 cycles.
- Send 12'hBA3 to the node-C instance → drop_count=1, out_valid stays 0, last_payload unchanged, rx_led stays 0.
- Send 12'hFD7 (broadcast) → accepted: out_src=D, out_payload=7, rx_count increments.
- Hold out_ready=0 and push 5 matching frames back-to-back (payloads 1..5) → rx_ready drops after the 4th. The 5th is held until one pop, and pops return 1,2,3,4,5 in order.
- With FIFO at 2 entries, push and pop in the same cycle for 10 cycles → count stays 2, pointers wrap cleanly, and data order is preserved.
- Assert FPGA_RST_BTN=0 mid-stream with 3 entries queued and rx_led=1 → immediately out_valid=0, rx_led=0, both counters 0, last_payload=0. After release, rx_ready=1.

Source files
------------

// File: rtl/node_frame_rx_pkg.sv
// Shared frame definitions for the node receive endpoint and the transmit-side encoders.
// Holds the address map, frame field positions and the address filter helper.
package node_frame_rx_pkg;

   localparam int FRAME_W = 12;
   localparam int ENTRY_W = 8;

   localparam logic [3:0] NODE_A     = 4'hA;
   localparam logic [3:0] NODE_B     = 4'hB;
   localparam logic [3:0] NODE_C     = 4'hC;
   localparam logic [3:0] NODE_D     = 4'hD;
   localparam logic [3:0] ADDR_BCAST = 4'hF;

   localparam int DST_HI = 11;
   localparam int DST_LO = 8;
   localparam int SRC_HI = 7;
   localparam int SRC_LO = 4;
   localparam int PAY_HI = 3;
   localparam int PAY_LO = 0;

   typedef struct packed {
      logic [3:0] src;
      logic [3:0] payload;
   } rx_entry_t;

   function automatic logic addr_match(input logic [3:0] dst, input logic [3:0] node);
      return (dst == node) || (dst == ADDR_BCAST);
   endfunction

endpackage

// File: rtl/node_frame_rx_if.sv
// Bundle of the egress-side and display-side signals of one node receive endpoint.
// The endpoint takes the slave view; the switch/display side takes the master view.
interface node_frame_rx_if;
   import node_frame_rx_pkg::*;

   logic               rx_valid;
   logic               rx_ready;
   logic [FRAME_W-1:0] rx_frame;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_src;
   logic [3:0]         out_payload;
   logic [3:0]         last_payload;
   logic               rx_led;
   logic [7:0]         rx_count;
   logic [7:0]         drop_count;

   modport slave (
      input  rx_valid, rx_frame, out_ready,
      output rx_ready, out_valid, out_src, out_payload,
             last_payload, rx_led, rx_count, drop_count
   );

   modport master (
      output rx_valid, rx_frame, out_ready,
      input  rx_ready, out_valid, out_src, out_payload,
             last_payload, rx_led, rx_count, drop_count
   );

endinterface

// File: rtl/node_rx_fifo.sv
// First-word-fall-through FIFO holding accepted {src,payload} entries.
// Push is ignored when full and pop is ignored when empty.
module node_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_s, pop_s;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == (AW+1)'(0));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_s  = push_i && !full_o;
   assign pop_s   = pop_i && !empty_o;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/node_frame_rx.sv
// Per-node receive endpoint: filters frames by destination, queues accepted ones,
// and maintains receive/drop counters plus a stretched receive LED.
module node_frame_rx
   import node_frame_rx_pkg::*;
#(
   parameter logic [3:0] NODE_ADDR  = NODE_A,
   parameter int         FIFO_DEPTH = 4,
   parameter int         LED_HOLD   = 16
) (
   input  logic            FPGA_CLK,
   input  logic            FPGA_RST_BTN,
   node_frame_rx_if.slave  bus
);
   logic        fifo_full_s, fifo_empty_s;
   logic [ENTRY_W-1:0] fifo_rdata_s;
   logic [$clog2(FIFO_DEPTH):0] fifo_level_unused_s;
   logic        xfer_s, accept_s, drop_s;
   rx_entry_t   push_entry_s, head_entry_s;

   logic [7:0]  rx_count_q, rx_count_d;
   logic [7:0]  drop_count_q, drop_count_d;
   logic [3:0]  last_payload_q, last_payload_d;
   logic [15:0] led_timer_q, led_timer_d;

   assign xfer_s   = bus.rx_valid && !fifo_full_s;
   assign accept_s = xfer_s && addr_match(bus.rx_frame[DST_HI:DST_LO], NODE_ADDR);
   assign drop_s   = xfer_s && !addr_match(bus.rx_frame[DST_HI:DST_LO], NODE_ADDR);

   assign push_entry_s.src     = bus.rx_frame[SRC_HI:SRC_LO];
   assign push_entry_s.payload = bus.rx_frame[PAY_HI:PAY_LO];
   assign head_entry_s         = rx_entry_t'(fifo_rdata_s);

   node_rx_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (FPGA_CLK),
      .rst_ni  (FPGA_RST_BTN),
      .push_i  (accept_s),
      .wdata_i (push_entry_s),
      .pop_i   (bus.out_ready),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_level_unused_s)
   );

   // Counter, last-payload and LED timer next-state; a reload beats the decrement.
   always_comb begin
      rx_count_d     = rx_count_q;
      drop_count_d   = drop_count_q;
      last_payload_d = last_payload_q;
      led_timer_d    = led_timer_q;
      if (led_timer_q != 16'd0) begin
         led_timer_d = led_timer_q - 16'd1;
      end else begin
         led_timer_d = led_timer_q;
      end
      if (accept_s) begin
         last_payload_d = push_entry_s.payload;
         led_timer_d    = 16'(LED_HOLD);
         if (rx_count_q != 8'hFF) begin
            rx_count_d = rx_count_q + 8'd1;
         end else begin
            rx_count_d = rx_count_q;
         end
      end else if (drop_s) begin
         if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end else begin
            drop_count_d = drop_count_q;
         end
      end else begin
         rx_count_d   = rx_count_q;
         drop_count_d = drop_count_q;
      end
   end

   // Status registers.
   always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
      if (!FPGA_RST_BTN) begin
         rx_count_q     <= 8'd0;
         drop_count_q   <= 8'd0;
         last_payload_q <= 4'd0;
         led_timer_q    <= 16'd0;
      end else begin
         rx_count_q     <= rx_count_d;
         drop_count_q   <= drop_count_d;
         last_payload_q <= last_payload_d;
         led_timer_q    <= led_timer_d;
      end
   end

   assign bus.rx_ready     = !fifo_full_s;
   assign bus.out_valid    = !fifo_empty_s;
   assign bus.out_src      = head_entry_s.src;
   assign bus.out_payload  = head_entry_s.payload;
   assign bus.last_payload = last_payload_q;
   assign bus.rx_led       = (led_timer_q != 16'd0);
   assign bus.rx_count     = rx_count_q;
   assign bus.drop_count   = drop_count_q;

endmodule

// File: tb/tb_node_frame_rx.sv
// Bench for node_frame_rx configured as node C: vector table plus corner-case
// sequences, with a queue scoreboard checked every cycle.
module tb_node_frame_rx;
   import node_frame_rx_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   node_frame_rx_if bus();

   node_frame_rx #(.NODE_ADDR(4'hC), .FIFO_DEPTH(4), .LED_HOLD(16)) dut (
      .FPGA_CLK     (clk),
      .FPGA_RST_BTN (rst_n),
      .bus          (bus)
   );

   typedef struct {
      logic [11:0] frame;
      bit          acc;
      logic [3:0]  src;
      logic [3:0]  pay;
   } vec_t;

   vec_t vecs[7];

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] m_q[$];
   int         m_rx, m_drop, m_timer;
   logic [3:0] m_last;

   function automatic bit tb_match(input logic [3:0] d);
      return (d == 4'hC) || (d == 4'hF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rx = 0; m_drop = 0; m_timer = 0; m_last = 4'h0;
   endtask

   // Check all outputs mid-cycle against the model, then advance one edge.
   task automatic tick();
      bit xfer, pop;
      @(negedge clk);
      chk("rx_ready", 32'(bus.rx_ready), 32'(m_q.size() < 4));
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("out_src", 32'(bus.out_src), 32'(m_q[0][7:4]));
         chk("out_payload", 32'(bus.out_payload), 32'(m_q[0][3:0]));
      end
      chk("last_payload", 32'(bus.last_payload), 32'(m_last));
      chk("rx_count", 32'(bus.rx_count), 32'(m_rx));
      chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
      chk("rx_led", 32'(bus.rx_led), 32'(m_timer != 0));
      xfer = bus.rx_valid && (m_q.size() < 4);
      pop  = bus.out_ready && (m_q.size() > 0);
      @(posedge clk);
      if (m_timer > 0) m_timer--;
      if (pop) void'(m_q.pop_front());
      if (xfer) begin
         if (tb_match(bus.rx_frame[11:8])) begin
            m_q.push_back(bus.rx_frame[7:0]);
            m_last  = bus.rx_frame[3:0];
            m_timer = 16;
            if (m_rx < 255) m_rx++;
         end else begin
            if (m_drop < 255) m_drop++;
         end
      end
      #1;
   endtask

   initial begin
      int cnt;
      int rx_before;
      logic [3:0] exp_last;
      logic [3:0] got[$];

      rst_n = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_frame  = 12'h000;
      bus.out_ready = 1'b0;
      model_reset();

      vecs[0] = '{12'hBA3, 1'b0, 4'h0, 4'h0};
      vecs[1] = '{12'hCA5, 1'b1, 4'hA, 4'h5};
      vecs[2] = '{12'hFD7, 1'b1, 4'hD, 4'h7};
      vecs[3] = '{12'h1C2, 1'b0, 4'h0, 4'h0};
      vecs[4] = '{12'hC00, 1'b1, 4'h0, 4'h0};
      vecs[5] = '{12'hFFF, 1'b1, 4'hF, 4'hF};
      vecs[6] = '{12'hDC9, 1'b0, 4'h0, 4'h0};

      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_rx_led", 32'(bus.rx_led), 32'd0);
      chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
      chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
      chk("rst_last_payload", 32'(bus.last_payload), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(bus.rx_ready), 32'd1);

      // Vector table: one frame per entry, then drain.
      exp_last = 4'h0;
      for (int i = 0; i < 7; i++) begin
         rx_before = m_rx;
         bus.rx_valid  = 1'b1;
         bus.rx_frame  = vecs[i].frame;
         bus.out_ready = 1'b0;
         tick();
         bus.rx_valid = 1'b0;
         if (vecs[i].acc) exp_last = vecs[i].pay;
         chk("vec_out_valid", 32'(bus.out_valid), 32'(vecs[i].acc));
         chk("vec_last", 32'(bus.last_payload), 32'(exp_last));
         chk("vec_rx_count", 32'(bus.rx_count), 32'(rx_before + int'(vecs[i].acc)));
         if (vecs[i].acc) begin
            chk("vec_src", 32'(bus.out_src), 32'(vecs[i].src));
            chk("vec_pay", 32'(bus.out_payload), 32'(vecs[i].pay));
            chk("vec_led", 32'(bus.rx_led), 32'd1);
         end
         bus.out_ready = 1'b1;
         tick();
      end
      chk("vec_drop_total", 32'(bus.drop_count), 32'd3);

      // LED stretch length after a single accept.
      cnt = 0;
      while (bus.rx_led && cnt < 100) begin cnt++; tick(); end
      bus.rx_valid = 1'b1; bus.rx_frame = 12'hCA5;
      tick();
      bus.rx_valid = 1'b0;
      cnt = 0;
      while (bus.rx_led && cnt < 100) begin cnt++; tick(); end
      chk("led_cycles", 32'(cnt), 32'd16);
      while (bus.out_valid && cnt < 200) begin cnt++; tick(); end

      // Fill to full with one frame held back, then drain in order.
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         bus.rx_valid = 1'b1;
         bus.rx_frame = {4'hC, 4'h1, 4'(i)};
         tick();
      end
      chk("full_ready", 32'(bus.rx_ready), 32'd0);
      rx_before = m_rx;
      bus.rx_frame = 12'hC15;
      for (int i = 0; i < 3; i++) tick();
      chk("held_rx_count", 32'(bus.rx_count), 32'(rx_before));
      bus.out_ready = 1'b1;
      cnt = 0;
      while (got.size() < 5 && cnt < 30) begin
         bit sent;
         sent = bus.rx_valid && bus.rx_ready;
         if (bus.out_valid) got.push_back(bus.out_payload);
         tick();
         if (sent) bus.rx_valid = 1'b0;
         cnt++;
      end
      chk("drain_len", 32'(got.size()), 32'd5);
      for (int i = 0; i < got.size(); i++) chk("drain_order", 32'(got[i]), 32'(i + 1));

      // Steady push+pop with two entries resident.
      bus.rx_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      bus.rx_valid = 1'b1; bus.rx_frame = 12'hC26; tick();
      bus.rx_frame = 12'hC27; tick();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.rx_frame = {4'hC, 4'h3, 4'(8 + i)};
         chk("steady_valid", 32'(bus.out_valid), 32'd1);
         tick();
      end
      bus.rx_valid = 1'b0;
      chk("steady_tail0", 32'(bus.out_payload), 32'h0);
      tick();
      chk("steady_tail1", 32'(bus.out_payload), 32'h1);
      tick();
      chk("steady_empty", 32'(bus.out_valid), 32'd0);

      // Counter saturation.
      bus.rx_valid = 1'b1; bus.rx_frame = 12'h5A1;
      for (int i = 0; i < 260; i++) tick();
      chk("drop_sat", 32'(bus.drop_count), 32'hFF);
      bus.rx_frame = 12'hC21;
      for (int i = 0; i < 260; i++) tick();
      chk("rx_sat", 32'(bus.rx_count), 32'hFF);
      bus.rx_valid = 1'b0;
      tick(); tick();

      // Asynchronous reset with three entries queued and LED lit.
      bus.out_ready = 1'b0;
      bus.rx_valid = 1'b1;
      bus.rx_frame = 12'hC19; tick();
      bus.rx_frame = 12'hC1A; tick();
      bus.rx_frame = 12'hC1B; tick();
      bus.rx_valid = 1'b0;
      chk("pre_rst_led", 32'(bus.rx_led), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_led", 32'(bus.rx_led), 32'd0);
      chk("mid_rst_rx_count", 32'(bus.rx_count), 32'd0);
      chk("mid_rst_drop_count", 32'(bus.drop_count), 32'd0);
      chk("mid_rst_last", 32'(bus.last_payload), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("rel_ready", 32'(bus.rx_ready), 32'd1);
      bus.rx_valid = 1'b1; bus.rx_frame = 12'hC3E;
      tick();
      bus.rx_valid = 1'b0;
      chk("rel_push_pay", 32'(bus.out_payload), 32'hE);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
